uart_in_responder: RTL and testbench
====================================

Name: uart_in_responder

Overview:
- Device-side responder for the processor's IN instruction: receives 8N1 serial bytes on Rx, buffers one byte, and answers IN requests with it.
- Holds the processor with BlockSystem while a request is pending and no byte is buffered.
- Sits beside the I/O module on the divided system Clock. Drives the DataIO / BlockSystem pair used by the register write-back mux and the program counter.

Parameters:
CLKS_PER_BIT, 8, Clock cycles per serial bit; minimum 4.
DATA_W, 32, width of DataIO. The received byte is zero-extended to this width.

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Rx  input  1  asynchronous serial line, idle high, 8N1, LSB first
InReq  input  1  level signal; high while an IN instruction is executing
DataIO  output  DATA_W  {zeros, buffered byte}; valid whenever Full=1
BlockSystem  output  1  stalls the PC; equals InReq & ~Full (combinational)
Full  output  1  one-byte holding buffer contains unread data
Overrun  output  1  sticky; a byte arrived while the buffer was full
FrameErr  output  1  sticky; stop bit sampled low

Behaviour:
- Reset (synchronous, active-high): receiver FSM to IDLE; bit counter, clock counter and shift register = 0; Buffer = 0; Full = 0; Overrun = 0; FrameErr = 0. DataIO therefore reads 0 and BlockSystem follows InReq. Reset mid-frame abandons the frame.
- Rx passes through a 2-flop synchronizer, initialised to 1 on reset. All FSM decisions use the synchronized value rxs, giving 2 cycles of input latency.
- FSM states:
  - IDLE: wait for rxs=0. On rxs=0, clear the clock counter and go to START.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division). At that point:
    - rxs=0: clear counter and bit index, go to DATA.
    - rxs=1: glitch; return to IDLE with no flag set.
  - DATA: count to CLKS_PER_BIT-1, then sample rxs into shift[bit index]. Bits arrive LSB first. After bit index 7 go to STOP; otherwise increment the index.
  - STOP: count to CLKS_PER_BIT-1, then sample rxs and return to IDLE.
    - rxs=1 and Full=0: Buffer <= shift; Full <= 1.
    - rxs=1 and Full=1: Overrun <= 1; Buffer keeps its old value; the new byte is discarded.
    - rxs=0: FrameErr <= 1; the byte is discarded.
- Consumption: on any edge where InReq=1 and Full=1, Full <= 0. The processor writes DataIO to its register on that same edge.
- Simultaneous store and consume on one edge (STOP commit with rxs=1 while InReq & Full): Buffer <= new byte, Full stays 1, no Overrun.
- Stall: BlockSystem rises in the same cycle InReq rises if Full=0. It falls in the cycle Full becomes 1. The request is answered on the first edge where both InReq and Full are 1.
- With InReq=0, Full and Buffer hold indefinitely.
- Overrun and FrameErr clear only on Reset.
- The counter width must hold CLKS_PER_BIT-1. The bit index is 3 bits. No arithmetic exceeds these widths.

Test Plan:
- Reset, then Rx idle for 20 cycles -> DataIO=0, Full=0, BlockSystem=0, both error flags 0.
- Send 0xA5 (CLKS_PER_BIT=8), then pulse InReq for 1 cycle -> Full=1 about 2+4+64+8 cycles after the start edge; DataIO=0x000000A5 while InReq is high; Full=0 after the edge; BlockSystem never 1.
- Raise InReq with the buffer empty, then send 0x3C -> BlockSystem=1 from the InReq rise until Full=1. In the Full cycle DataIO=0x0000003C and BlockSystem=0; Full clears on the next edge.
- Send 0x11 then 0x22 with no InReq -> Overrun=1 and DataIO=0x00000011; Overrun stays 1 after a subsequent read until Reset.
- Send a frame with stop bit 0 (byte 0x55) -> FrameErr=1 and Full remains 0. A 2-cycle low glitch on Rx -> no flags set and the FSM returns to IDLE.
- Assert Reset in the middle of the DATA bits of 0xF0 -> all outputs 0 on the next cycle. A following clean 0x0F is received correctly.

Source files
------------

// File: rtl/uart_in_responder.sv
// uart_in_responder
// -----------------------------------------------------------------------------
// Device-side responder for the processor's IN instruction. An 8N1 serial
// receiver (LSB first, idle high) feeds a one-byte holding buffer. An IN
// request (InReq) is answered from that buffer. While a request is pending and
// the buffer is empty, BlockSystem stalls the processor.
//
// Ports:
//   Clock       in   system clock, all state updates on the rising edge
//   Reset       in   synchronous, active-high reset
//   Rx          in   asynchronous serial line (idle high, 8N1, LSB first)
//   InReq       in   level, high while an IN instruction executes
//   DataIO      out  {zeros, buffered byte}, valid whenever Full=1
//   BlockSystem out  InReq & ~Full (combinational stall)
//   Full        out  holding buffer contains unread data
//   Overrun     out  sticky, a byte arrived while the buffer was full
//   FrameErr    out  sticky, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_in_responder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Rx,
  input  logic              InReq,
  output logic [DATA_W-1:0] DataIO,
  output logic              BlockSystem,
  output logic              Full,
  output logic              Overrun,
  output logic              FrameErr
);

  // The counter only has to reach CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_sync;
  logic             w_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             w_stop_sample;
  logic             w_commit;
  logic             w_frame_err;
  logic             w_consume;
  logic [7:0]       r_buf;
  logic             r_full;
  logic             r_ovr;
  logic             r_ferr;

  // Two-flop synchronizer; reset to the idle level so no false start is seen.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], Rx};
    end
  end

  assign w_rxs = r_sync[1];

  // Receiver state register and datapath registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  // Receiver next-state logic.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + 1'b1;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_stop_sample = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!w_rxs) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit; a high level here is a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_next = '0;
          w_bit_next = '0;
          w_state_next = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          w_shift_next[r_bit] = w_rxs;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next    = '0;
          w_stop_sample = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_commit    = w_stop_sample & w_rxs;
  assign w_frame_err = w_stop_sample & ~w_rxs;
  assign w_consume   = InReq & r_full;

  // Holding buffer. A read on the same edge as a new byte frees the slot, so
  // the new byte is stored and no overrun is flagged.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_buf  <= '0;
      r_full <= 1'b0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_commit && (!r_full || InReq)) begin
        r_buf  <= r_shift;
        r_full <= 1'b1;
      end else if (w_consume) begin
        r_full <= 1'b0;
      end
      if (w_commit && r_full && !InReq) begin
        r_ovr <= 1'b1;
      end
      if (w_frame_err) begin
        r_ferr <= 1'b1;
      end
    end
  end

  assign DataIO      = {{(DATA_W - 8){1'b0}}, r_buf};
  assign BlockSystem = InReq & ~r_full;
  assign Full        = r_full;
  assign Overrun     = r_ovr;
  assign FrameErr    = r_ferr;

endmodule

// File: tb/tb_uart_in_responder.sv
// Testbench for uart_in_responder: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase scored against a
// byte-level buffer model.
module tb_uart_in_responder;

  localparam int CPB = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Rx    = 1'b1;
  logic        InReq = 1'b0;
  logic [31:0] DataIO;
  logic        BlockSystem;
  logic        Full;
  logic        Overrun;
  logic        FrameErr;

  int checks   = 0;
  int failures = 0;

  uart_in_responder #(.CLKS_PER_BIT(CPB), .DATA_W(32)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Rx(Rx),
    .InReq(InReq),
    .DataIO(DataIO),
    .BlockSystem(BlockSystem),
    .Full(Full),
    .Overrun(Overrun),
    .FrameErr(FrameErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_ovr;
    logic       e_ferr;
  } vec_t;

  vec_t tbl[5];

  // Byte-level model used in the randomized phase.
  logic       m_full;
  logic [7:0] m_buf;
  logic       m_ovr;
  logic       m_ferr;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Drive the first nbits of a 10-bit 8N1 frame, then return the line to idle.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      Rx = f[i];
      step(CPB);
    end
    Rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    drive_frame(d, stop, 10);
    step(10);
  endtask

  task automatic check_state(input string pfx, input logic ef, input logic [7:0] ed,
                             input logic eo, input logic efe, input logic eb);
    @(negedge Clock);
    chk1({pfx, "_full"}, Full, ef);
    chk32({pfx, "_data"}, DataIO, {24'h0, ed});
    chk1({pfx, "_ovr"}, Overrun, eo);
    chk1({pfx, "_ferr"}, FrameErr, efe);
    chk1({pfx, "_blk"}, BlockSystem, eb);
    @(posedge Clock);
    #1;
  endtask

  task automatic read_pulse(input string pfx, input logic ef, input logic [7:0] ed);
    InReq = 1'b1;
    @(negedge Clock);
    chk1({pfx, "_rd_blk"}, BlockSystem, !ef);
    if (ef) chk32({pfx, "_rd_data"}, DataIO, {24'h0, ed});
    @(posedge Clock);
    #1;
    InReq = 1'b0;
    chk1({pfx, "_rd_cleared"}, Full, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[2] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1};

    // Reset and idle line.
    step(3);
    Reset = 1'b0;
    step(20);
    check_state("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Directed frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, tbl[i].stop);
      check_state($sformatf("vec%0d", i), tbl[i].e_full, tbl[i].e_data,
                  tbl[i].e_ovr, tbl[i].e_ferr, 1'b0);
      if (tbl[i].rd) read_pulse($sformatf("vec%0d", i), tbl[i].e_full, tbl[i].e_data);
    end

    // Stall: request raised with the buffer empty, then the byte arrives.
    InReq = 1'b1;
    @(negedge Clock);
    chk1("stall_rise_blk", BlockSystem, 1'b1);
    @(posedge Clock);
    #1;
    fork
      drive_frame(8'h3C, 1'b1, 10);
      begin
        int   n;
        logic blk_ok;
        logic seen;
        n      = 0;
        blk_ok = 1'b1;
        seen   = 1'b0;
        while (n < 300 && !seen) begin
          @(negedge Clock);
          if (Full) seen = 1'b1;
          else if (!BlockSystem) blk_ok = 1'b0;
          n++;
        end
        chk1("stall_full_seen", seen, 1'b1);
        chk1("stall_blk_held", blk_ok, 1'b1);
        chk32("stall_data", DataIO, 32'h0000003C);
        chk1("stall_blk_released", BlockSystem, 1'b0);
        @(posedge Clock);
        #1;
        chk1("stall_consumed", Full, 1'b0);
        InReq = 1'b0;
      end
    join
    step(10);

    // Reset in the middle of the data bits of 0xF0, with the buffer full.
    send(8'h77, 1'b1);
    drive_frame(8'hF0, 1'b1, 5);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    chk1("rst_full", Full, 1'b0);
    chk32("rst_data", DataIO, 32'h0);
    chk1("rst_ovr", Overrun, 1'b0);
    chk1("rst_ferr", FrameErr, 1'b0);
    chk1("rst_blk", BlockSystem, 1'b0);
    step(5);
    send(8'h0F, 1'b1);
    check_state("post_rst", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    read_pulse("post_rst", 1'b1, 8'h0F);

    // Store and consume on the same edge: the read lands on the stop commit.
    send(8'h5A, 1'b1);
    fork
      drive_frame(8'hC3, 1'b1, 10);
      begin
        step(78);
        InReq = 1'b1;
        step(1);
        InReq = 1'b0;
      end
    join
    step(10);
    check_state("simul", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    read_pulse("simul", 1'b1, 8'hC3);

    // Two-cycle glitch: no flags, and the receiver still takes a clean byte.
    Rx = 1'b0;
    step(2);
    Rx = 1'b1;
    step(20);
    check_state("glitch", 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'h96, 1'b1);
    check_state("after_glitch", 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
    read_pulse("after_glitch", 1'b1, 8'h96);

    // Randomized frames and reads against the byte-level model.
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    m_full = 1'b0;
    m_buf  = 8'h00;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       stop;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      step($urandom_range(1, 15));
      send(d, stop);
      if (!stop) m_ferr = 1'b1;
      else if (m_full) m_ovr = 1'b1;
      else begin
        m_buf  = d;
        m_full = 1'b1;
      end
      check_state($sformatf("rnd%0d", i), m_full, m_buf, m_ovr, m_ferr, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        read_pulse($sformatf("rnd%0d", i), m_full, m_buf);
        m_full = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
